// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared definitions for the game sequencing controller:
//                state width, state encodings and the lives counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    localparam int c_state_w = 3;
    localparam int c_lives_w = 4;

    typedef enum logic [c_state_w-1:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_PAUSE = 3'd2,
        ST_HIT   = 3'd3,
        ST_OVER  = 3'd4
    } game_state_t;

endpackage : game_pkg
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Conditions one raw asynchronous push-button. Two-flop
//                synchroniser, then a debouncer that accepts a new level
//                only after DEBOUNCE_CYCLES consecutive cycles of
//                disagreement, then a rising-edge detector on the accepted
//                level producing a one-cycle press event.
//  Ports       : clk     - system clock
//                rst_n   - asynchronous active-low reset
//                i_key   - raw key, active high
//                o_press - one-cycle pulse per accepted press
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key,
    output logic o_press
);

    localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_level_d;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_key;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            // Any cycle of agreement restarts the run of disagreeing cycles.
            if (r_sync2 != r_level) begin
                if (r_cnt == c_cnt_last) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // Both terms are flops, so the pulse is glitch-free and lasts one cycle.
    assign o_press = r_level & ~r_level_d;

endmodule : key_debounce
`default_nettype wire

// File: rtl/game_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : game_seq_ctrl
//  Description : Top-level game sequencer. Debounces the jump and pause keys
//                and runs the IDLE/PLAY/PAUSE/HIT/OVER state machine that
//                tracks lives, score, best score and the respawn delay.
//  Ports       : clk, rst_n   - clock, asynchronous active-low reset
//                key_jump     - raw jump/start key
//                key_pause    - raw pause key
//                collision    - synchronous collision level
//                score_tick   - synchronous one-cycle score pulse
//                game_active  - high while in PLAY
//                state        - current state encoding
//                lives_left   - remaining lives
//                score        - current score (saturating)
//                high_score   - best score since reset
//                jump_pulse   - one-cycle flap command
//  Revision    : 1.0 - initial release
// ============================================================================
module game_seq_ctrl
    import game_pkg::*;
#(
    parameter int LIVES           = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RESPAWN_CYCLES  = 25000000,
    parameter int SCORE_W         = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_jump,
    input  logic                 key_pause,
    input  logic                 collision,
    input  logic                 score_tick,
    output logic                 game_active,
    output logic [c_state_w-1:0] state,
    output logic [c_lives_w-1:0] lives_left,
    output logic [SCORE_W-1:0]   score,
    output logic [SCORE_W-1:0]   high_score,
    output logic                 jump_pulse
);

    localparam int c_resp_w = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;
    localparam logic [c_resp_w-1:0]  c_resp_load = c_resp_w'(RESPAWN_CYCLES - 1);
    localparam logic [c_lives_w-1:0] c_lives     = c_lives_w'(LIVES);
    localparam logic [SCORE_W-1:0]   c_score_max = '1;

    logic w_jump_ev;
    logic w_pause_ev;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_jump_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_key   (key_jump),
        .o_press (w_jump_ev)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_pause_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_key   (key_pause),
        .o_press (w_pause_ev)
    );

    game_state_t          r_state;
    logic [c_lives_w-1:0] r_lives;
    logic [SCORE_W-1:0]   r_score;
    logic [SCORE_W-1:0]   r_high;
    logic [c_resp_w-1:0]  r_resp;

    game_state_t          w_state_nxt;
    logic [c_lives_w-1:0] w_lives_nxt;
    logic [SCORE_W-1:0]   w_score_nxt;
    logic [SCORE_W-1:0]   w_high_nxt;
    logic [c_resp_w-1:0]  w_resp_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_lives <= '0;
            r_score <= '0;
            r_high  <= '0;
            r_resp  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lives <= w_lives_nxt;
            r_score <= w_score_nxt;
            r_high  <= w_high_nxt;
            r_resp  <= w_resp_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lives_nxt = r_lives;
        w_score_nxt = r_score;
        w_high_nxt  = r_high;
        w_resp_nxt  = r_resp;
        case (r_state)
            ST_IDLE: begin
                if (w_jump_ev) begin
                    w_state_nxt = ST_PLAY;
                    w_lives_nxt = c_lives;
                    w_score_nxt = '0;
                end
            end
            ST_PLAY: begin
                // Collision wins over everything; a coincident score_tick
                // is dropped so the score at game end is the pre-hit value.
                if (collision) begin
                    if (r_lives > 4'd1) begin
                        w_state_nxt = ST_HIT;
                        w_lives_nxt = r_lives - 1'b1;
                        w_resp_nxt  = c_resp_load;
                    end else begin
                        w_state_nxt = ST_OVER;
                        w_lives_nxt = '0;
                        if (r_score > r_high) begin
                            w_high_nxt = r_score;
                        end
                    end
                end else if (w_pause_ev) begin
                    w_state_nxt = ST_PAUSE;
                end else if (score_tick && (r_score != c_score_max)) begin
                    w_score_nxt = r_score + 1'b1;
                end
            end
            ST_PAUSE: begin
                if (w_pause_ev) begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_HIT: begin
                // Loaded with RESPAWN_CYCLES-1 on entry; the extra cycle
                // spent at zero makes HIT last exactly RESPAWN_CYCLES.
                if (r_resp == '0) begin
                    w_state_nxt = ST_PLAY;
                end else begin
                    w_resp_nxt = r_resp - 1'b1;
                end
            end
            ST_OVER: begin
                if (w_jump_ev) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Flap is issued on any jump event seen while in PLAY; both terms come
    // from flops so the pulse needs no extra register stage.
    assign jump_pulse  = (r_state == ST_PLAY) && w_jump_ev;
    assign game_active = (r_state == ST_PLAY);
    assign state       = r_state;
    assign lives_left  = r_lives;
    assign score       = r_score;
    assign high_score  = r_high;

endmodule : game_seq_ctrl
`default_nettype wire

// File: tb/tb_game_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_seq_ctrl
//  Description : Directed self-checking bench for game_seq_ctrl with
//                DEBOUNCE_CYCLES=4, RESPAWN_CYCLES=8, LIVES=3, SCORE_W=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_seq_ctrl;

    localparam int c_db    = 4;
    localparam int c_resp  = 8;
    localparam int c_lives = 3;
    localparam int c_sw    = 4;

    localparam int c_idle  = 0;
    localparam int c_play  = 1;
    localparam int c_pause = 2;
    localparam int c_hit   = 3;
    localparam int c_over  = 4;

    logic            clk;
    logic            rst_n;
    logic            key_jump;
    logic            key_pause;
    logic            collision;
    logic            score_tick;
    logic            game_active;
    logic [2:0]      state;
    logic [3:0]      lives_left;
    logic [c_sw-1:0] score;
    logic [c_sw-1:0] high_score;
    logic            jump_pulse;

    int n_checks = 0;
    int n_pass   = 0;

    game_seq_ctrl #(
        .LIVES           (c_lives),
        .DEBOUNCE_CYCLES (c_db),
        .RESPAWN_CYCLES  (c_resp),
        .SCORE_W         (c_sw)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_jump    (key_jump),
        .key_pause   (key_pause),
        .collision   (collision),
        .score_tick  (score_tick),
        .game_active (game_active),
        .state       (state),
        .lives_left  (lives_left),
        .score       (score),
        .high_score  (high_score),
        .jump_pulse  (jump_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold a key for 'hold' cycles, release, let the release settle; count
    // jump pulses seen throughout.
    task automatic press(input bit is_pause, input int hold, output int jumps);
        jumps = 0;
        if (is_pause) key_pause = 1'b1; else key_jump = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (jump_pulse) jumps++;
        end
        key_pause = 1'b0;
        key_jump  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (jump_pulse) jumps++;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            score_tick = 1'b1;
            tick();
            score_tick = 1'b0;
            tick();
        end
    endtask

    // Collision from PLAY with lives remaining: check entry, HIT length and
    // that game_active stays low, all within a bounded wait.
    task automatic hit(input int exp_lives);
        int n;
        bit act;
        collision = 1'b1;
        tick();
        collision = 1'b0;
        chk("hit_state", state, c_hit);
        chk("hit_lives", lives_left, exp_lives);
        n = 0;
        act = 1'b0;
        while (state == c_hit && n < 50) begin
            if (game_active) act = 1'b1;
            n++;
            tick();
        end
        chk("hit_len", n, c_resp);
        chk("hit_active", act, 0);
        chk("hit_back_play", state, c_play);
    endtask

    task automatic lose_game(input int exp_score, input int exp_high);
        hit(2);
        hit(1);
        collision = 1'b1;
        tick();
        collision = 1'b0;
        chk("over_state", state, c_over);
        chk("over_lives", lives_left, 0);
        chk("over_score", score, exp_score);
        chk("over_high", high_score, exp_high);
    endtask

    initial begin
        int j;
        rst_n      = 1'b0;
        key_jump   = 1'b0;
        key_pause  = 1'b0;
        collision  = 1'b0;
        score_tick = 1'b0;
        tick();
        chk("rst_state", state, c_idle);
        chk("rst_active", game_active, 0);
        chk("rst_jump", jump_pulse, 0);
        chk("rst_lives", lives_left, 0);
        chk("rst_score", score, 0);
        chk("rst_high", high_score, 0);
        rst_n = 1'b1;
        tick();

        // Short press is rejected by the debouncer.
        press(1'b0, 3, j);
        chk("short_idle", state, c_idle);

        // Long press starts exactly one game.
        press(1'b0, 10, j);
        chk("start_state", state, c_play);
        chk("start_lives", lives_left, c_lives);
        chk("start_score", score, 0);
        chk("start_nojump", j, 0);
        chk("start_active", game_active, 1);

        // Jump in PLAY gives exactly one flap.
        press(1'b0, 10, j);
        chk("play_jumps", j, 1);
        chk("play_stays", state, c_play);

        // Game 1: score 5, lose all lives, best becomes 5.
        ticks(5);
        chk("g1_score", score, 5);
        lose_game(5, 5);
        press(1'b0, 10, j);
        chk("over_to_idle", state, c_idle);
        chk("idle_score_held", score, 5);
        chk("idle_nojump", j, 0);

        // Game 2: score 3, best stays 5.
        press(1'b0, 10, j);
        chk("g2_start", state, c_play);
        chk("g2_lives", lives_left, c_lives);
        chk("g2_score0", score, 0);
        ticks(3);
        lose_game(3, 5);
        press(1'b0, 10, j);

        // Game 3: pause behaviour, coincident hit, reset during HIT.
        press(1'b0, 10, j);
        chk("g3_start", state, c_play);
        ticks(2);
        press(1'b1, 10, j);
        chk("pause_state", state, c_pause);
        chk("pause_active", game_active, 0);
        collision  = 1'b1;
        score_tick = 1'b1;
        tick();
        collision  = 1'b0;
        score_tick = 1'b0;
        tick();
        chk("pause_hold_state", state, c_pause);
        chk("pause_hold_score", score, 2);
        chk("pause_hold_lives", lives_left, c_lives);
        press(1'b0, 10, j);
        chk("pause_nojump", j, 0);
        chk("pause_jump_ign", state, c_pause);
        press(1'b1, 10, j);
        chk("resume_state", state, c_play);

        collision  = 1'b1;
        score_tick = 1'b1;
        tick();
        collision  = 1'b0;
        score_tick = 1'b0;
        chk("coinc_state", state, c_hit);
        chk("coinc_score", score, 2);
        chk("coinc_lives", lives_left, 2);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("hrst_state", state, c_idle);
        chk("hrst_active", game_active, 0);
        chk("hrst_jump", jump_pulse, 0);
        chk("hrst_lives", lives_left, 0);
        chk("hrst_score", score, 0);
        chk("hrst_high", high_score, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Game 4: saturation.
        press(1'b0, 10, j);
        chk("g4_start", state, c_play);
        ticks(14);
        chk("sat_14", score, 14);
        ticks(3);
        chk("sat_17", score, 15);
        chk("sat_state", state, c_play);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_game_seq_ctrl
`default_nettype wire
